// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: D-stage instruction fields in, stall/forward/md controls out
interface hazard_scoreboard_if #(parameter int DEPTH = 3, parameter int TNEW_W = 2);
   localparam int SEL_W = $clog2(DEPTH + 1);
   logic d_valid;
   logic [4:0] d_rs, d_rt, d_wb;
   logic [TNEW_W-1:0] d_rs_tuse, d_rt_tuse, d_tnew;
   logic d_md_start, d_md_div, d_md_use;
   logic stall_pc, stall_d, bubble_e, md_busy;
   logic [SEL_W-1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
   logic [31:0] stat_data, stat_md;
   modport master (
      output d_valid, d_rs, d_rt, d_wb, d_rs_tuse, d_rt_tuse, d_tnew, d_md_start, d_md_div, d_md_use,
      input stall_pc, stall_d, bubble_e, md_busy, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, stat_data, stat_md
   );
   modport slave (
      input d_valid, d_rs, d_rt, d_wb, d_rs_tuse, d_rt_tuse, d_tnew, d_md_start, d_md_div, d_md_use,
      output stall_pc, stall_d, bubble_e, md_busy, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, stat_data, stat_md
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight write tracking, forwarding selects, stalls and mult/div busy; HAZARD_STATS_EN adds stall counters
module hazard_scoreboard #(
   parameter int DEPTH = 3,
   parameter int TNEW_W = 2,
   parameter int MULT_LAT = 5,
   parameter int DIV_LAT = 10
) (
   input logic clk,
   input logic reset,
   hazard_scoreboard_if.slave sb
);
   localparam int SEL_W = $clog2(DEPTH + 1);
   localparam int CNT_W = $clog2((MULT_LAT > DIV_LAT ? MULT_LAT : DIV_LAT) + 1);
   typedef struct packed {
      logic v, md, div;
      logic [4:0] wb, rs, rt;
      logic [TNEW_W-1:0] tnew;
   } entry_t;
   typedef enum logic {IDLE, BUSY} state_t;
   entry_t e [1:DEPTH];
   state_t state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic data_stall, md_stall, stall, md_go;
   function automatic logic hit(input logic [4:0] r, input int k);
      return e[k].v && e[k].wb != 5'd0 && e[k].wb == r;
   endfunction
   // scanning oldest to youngest lets the youngest match overwrite the result
   function automatic logic late(input logic [4:0] r, input logic [TNEW_W-1:0] tuse);
      late = 1'b0;
      for (int k = DEPTH; k >= 1; k--)
         if (hit(r, k)) late = e[k].tnew > tuse;
   endfunction
   function automatic logic [SEL_W-1:0] sel(input logic [4:0] r, input int lo);
      sel = '0;
      for (int k = DEPTH; k >= lo; k--)
         if (hit(r, k)) sel = e[k].tnew == '0 ? SEL_W'(k) : '0;
   endfunction
   always_comb begin
      md_go = e[1].v && e[1].md;
      data_stall = sb.d_valid && (late(sb.d_rs, sb.d_rs_tuse) || late(sb.d_rt, sb.d_rt_tuse));
      md_stall = sb.d_md_use && (state == BUSY || md_go);
      stall = data_stall || md_stall;
      state_nx = state == IDLE ? (md_go ? BUSY : IDLE) : (cnt == CNT_W'(1) ? IDLE : BUSY);
      cnt_nx = state == IDLE ? (md_go ? (e[1].div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT)) : '0) : cnt - 1'b1;
   end
   assign sb.stall_pc = stall;
   assign sb.stall_d = stall;
   assign sb.bubble_e = stall;
   assign sb.md_busy = state == BUSY;
   assign sb.fwd_d_rs = sel(sb.d_rs, 1);
   assign sb.fwd_d_rt = sel(sb.d_rt, 1);
   assign sb.fwd_e_rs = e[1].v ? sel(e[1].rs, 2) : '0;
   assign sb.fwd_e_rt = e[1].v ? sel(e[1].rt, 2) : '0;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         for (int k = 1; k <= DEPTH; k++) e[k] <= '0;
      end else begin
         e[1] <= (sb.d_valid && !stall) ?
            entry_t'({1'b1, sb.d_md_start, sb.d_md_div, sb.d_wb, sb.d_rs, sb.d_rt, sb.d_tnew}) : '0;
         for (int k = 2; k <= DEPTH; k++) begin
            e[k] <= e[k-1];
            e[k].tnew <= e[k-1].tnew == '0 ? '0 : e[k-1].tnew - 1'b1;
         end
      end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= IDLE;
         cnt <= '0;
      end else begin
         state <= state_nx;
         cnt <= cnt_nx;
      end
`ifdef HAZARD_STATS_EN
   logic [31:0] n_data, n_md;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         n_data <= '0;
         n_md <= '0;
      end else begin
         n_data <= n_data + {31'd0, data_stall && !(&n_data)};
         n_md <= n_md + {31'd0, md_stall && !(&n_md)};
      end
   assign sb.stat_data = n_data;
   assign sb.stat_md = n_md;
`else
   assign sb.stat_data = '0;
   assign sb.stat_md = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed pipeline scenarios plus random instruction streams against an in-flight instruction model
module tb_hazard_scoreboard;
   localparam int DEPTH = 3, TNEW_W = 2, MULT_LAT = 5, DIV_LAT = 10;
   typedef struct {bit v, md, div; int wb, rs, rt, tnew;} ins_t;
   logic clk = 1'b0, reset = 1'b0;
   int checks = 0, fails = 0;
   ins_t pipe [1:DEPTH];
   int busy_left = 0;
   longint st_data = 0, st_md = 0;
   bit exp_stall = 0;
   always #5 clk = ~clk;
   hazard_scoreboard_if #(.DEPTH(DEPTH), .TNEW_W(TNEW_W)) sb ();
   hazard_scoreboard #(.DEPTH(DEPTH), .TNEW_W(TNEW_W), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT))
      dut (.clk(clk), .reset(reset), .sb(sb));
   task automatic check(input string tag, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask
   // an instruction issued with tnew t has max(0, t-(k-1)) cycles left once it sits in stage k
   function automatic int stage_tnew(int k);
      int t = pipe[k].tnew - (k - 1);
      return t < 0 ? 0 : t;
   endfunction
   function automatic int youngest(int r, int lo);
      for (int k = lo; k <= DEPTH; k++)
         if (r != 0 && pipe[k].v && pipe[k].wb == r) return k;
      return 0;
   endfunction
   function automatic int fwd(int r, int lo);
      int k = youngest(r, lo);
      return (k != 0 && stage_tnew(k) == 0) ? k : 0;
   endfunction
   function automatic bit late(int r, int tuse);
      int k = youngest(r, 1);
      return k != 0 && stage_tnew(k) > tuse;
   endfunction
   function automatic longint stat(longint n);
`ifdef HAZARD_STATS_EN
      return n;
`else
      return 0;
`endif
   endfunction
   task automatic drive(input bit v, input int wb, tnew, rs, rs_tuse, rt, rt_tuse, input bit ms, md, mu);
      sb.d_valid = v;
      sb.d_wb = 5'(wb);
      sb.d_tnew = TNEW_W'(tnew);
      sb.d_rs = 5'(rs);
      sb.d_rs_tuse = TNEW_W'(rs_tuse);
      sb.d_rt = 5'(rt);
      sb.d_rt_tuse = TNEW_W'(rt_tuse);
      sb.d_md_start = ms;
      sb.d_md_div = md;
      sb.d_md_use = mu;
   endtask
   task automatic model_reset();
      for (int k = 1; k <= DEPTH; k++) pipe[k] = '{default: 0};
      busy_left = 0;
      st_data = 0;
      st_md = 0;
      exp_stall = 0;
   endtask
   task automatic step();
      bit ds, ms;
      ins_t n;
      #1;
      ds = sb.d_valid && (late(sb.d_rs, sb.d_rs_tuse) || late(sb.d_rt, sb.d_rt_tuse));
      ms = sb.d_md_use && (busy_left > 0 || (pipe[1].v && pipe[1].md));
      exp_stall = ds || ms;
      check("stall_pc", sb.stall_pc, exp_stall);
      check("stall_d", sb.stall_d, exp_stall);
      check("bubble_e", sb.bubble_e, exp_stall);
      check("fwd_d_rs", sb.fwd_d_rs, fwd(sb.d_rs, 1));
      check("fwd_d_rt", sb.fwd_d_rt, fwd(sb.d_rt, 1));
      check("fwd_e_rs", sb.fwd_e_rs, pipe[1].v ? fwd(pipe[1].rs, 2) : 0);
      check("fwd_e_rt", sb.fwd_e_rt, pipe[1].v ? fwd(pipe[1].rt, 2) : 0);
      check("md_busy", sb.md_busy, busy_left > 0);
      check("stat_data", sb.stat_data, stat(st_data));
      check("stat_md", sb.stat_md, stat(st_md));
      n = '{v: sb.d_valid && !exp_stall, md: sb.d_md_start, div: sb.d_md_div, wb: sb.d_wb,
            rs: sb.d_rs, rt: sb.d_rt, tnew: sb.d_tnew};
      @(posedge clk);
      if (ds) st_data++;
      if (ms) st_md++;
      for (int k = DEPTH; k >= 2; k--) pipe[k] = pipe[k-1];
      pipe[1] = n;
      if (busy_left > 0) busy_left--;
      if (pipe[2].v && pipe[2].md) busy_left = pipe[2].div ? DIV_LAT : MULT_LAT;
      #1;
   endtask
   task automatic issue(input int wb, tnew, rs, rs_tuse, rt, rt_tuse, input bit ms = 0, md = 0, mu = 0);
      drive(1, wb, tnew, rs, rs_tuse, rt, rt_tuse, ms, md, mu);
      for (int i = 0; i < 40; i++) begin
         step();
         if (!exp_stall) return;
      end
      check("issue_timeout", 1, 0);
   endtask
   task automatic nop(input int n);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (n) step();
   endtask
   task automatic check_idle(input string tag);
      check({tag, "_stall"}, sb.stall_pc | sb.stall_d | sb.bubble_e, 0);
      check({tag, "_fwd_d_rs"}, sb.fwd_d_rs, 0);
      check({tag, "_fwd_d_rt"}, sb.fwd_d_rt, 0);
      check({tag, "_fwd_e_rs"}, sb.fwd_e_rs, 0);
      check({tag, "_fwd_e_rt"}, sb.fwd_e_rt, 0);
      check({tag, "_md_busy"}, sb.md_busy, 0);
      check({tag, "_stats"}, sb.stat_data | sb.stat_md, 0);
   endtask
   initial begin
      model_reset();
      drive(1, 1, 2, 1, 0, 1, 0, 1, 1, 1);
      repeat (3) @(posedge clk);
      #1;
      check_idle("reset");
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;
      issue(1, 2, 0, 0, 0, 0);
      issue(4, 1, 1, 1, 0, 0);
      nop(3);
      issue(2, 1, 0, 0, 0, 0);
      issue(0, 0, 2, 0, 0, 0);
      nop(3);
      issue(31, 0, 0, 0, 0, 0);
      issue(0, 0, 31, 0, 0, 0);
      nop(3);
      issue(3, 1, 0, 0, 0, 0);
      issue(3, 1, 0, 0, 0, 0);
      issue(5, 1, 3, 1, 0, 0);
      nop(3);
      issue(0, 0, 6, 0, 7, 0, 1, 1, 1);
      issue(8, 1, 0, 0, 0, 0, 0, 0, 1);
      nop(3);
      issue(0, 2, 0, 0, 0, 0);
      issue(0, 0, 0, 0, 0, 0);
      nop(3);
      issue(0, 0, 1, 0, 2, 0, 1, 0, 1);
      issue(9, 1, 0, 0, 0, 0, 0, 0, 1);
      nop(2);
      for (int i = 0; i < 600; i++) begin
         if (!exp_stall) begin
            bit v = $urandom_range(0, 9) != 0;
            bit ms = v && $urandom_range(0, 15) == 0;
            drive(v, ms ? 0 : $urandom_range(0, 4), $urandom_range(0, 3),
                  $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3),
                  ms, $urandom_range(0, 1) == 1, v && (ms || $urandom_range(0, 7) == 0));
         end
         step();
      end
      nop(12);
      issue(0, 0, 0, 0, 0, 0, 1, 1, 1);
      issue(5, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 5, 0, 5, 0, 0, 0, 0);
      step();
      drive(1, 0, 0, 5, 0, 5, 0, 0, 0, 0);
      #2 reset = 1'b0;
      #1;
      model_reset();
      check_idle("async_reset");
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;
      nop(4);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
